sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 The block SHALL have parameter SIZE, default 8, depth in words; power of two, at least 2.
REQ-003 The block SHALL have parameter PTR_LEN, default $clog2(SIZE), address width.
REQ-004 The block SHALL have parameter AFULL_TH, default SIZE-2, almost-full threshold in words.
REQ-005 The block SHALL have parameter AEMPTY_TH, default 1, almost-empty threshold in words.
REQ-006 The block SHALL have parameter FWFT, default 0; 0 selects standard read, 1 selects first-word-fall-through.
REQ-007 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-008 The block SHALL have port arst, input, 1 bit: reset, asynchronous, active-high.
REQ-009 The block SHALL have port w_en, input, 1 bit: write request.
REQ-010 The block SHALL have port data_in, input, WIDTH bits: write data.
REQ-011 The block SHALL have port r_en, input, 1 bit: read request (pop in FWFT mode).
REQ-012 The block SHALL have port data_out, output, WIDTH bits: read data.
REQ-013 The block SHALL have ports full, empty, almost_full and almost_empty, each an output of 1 bit carrying the status flags.
REQ-014 The block SHALL have port count, output, PTR_LEN+1 bits: stored words, 0..SIZE.

Function
REQ-015 A write SHALL be accepted iff w_en=1 and full=0; data_in is stored at wr_ptr and wr_ptr increments.
REQ-016 A read SHALL be accepted iff r_en=1 and empty=0; rd_ptr increments.
REQ-017 Pointers SHALL be PTR_LEN+1 bits and wrap modulo 2*SIZE; the MSB distinguishes full from empty.
REQ-018 When a write and a read are both accepted in one cycle, count SHALL be unchanged.
REQ-019 A write while full SHALL be dropped even if a read is accepted in the same cycle.
REQ-020 count, full (count==SIZE), empty (count==0), almost_full (count>=AFULL_TH) and almost_empty (count<=AEMPTY_TH) SHALL be registered and SHALL reflect accepted operations one cycle after the clock edge.
REQ-021 With FWFT=0, data_out SHALL be registered, SHALL update 1 cycle after an accepted read, and SHALL hold its value otherwise.
REQ-022 With FWFT=1, data_out SHALL equal the head word whenever empty=0; the first write into an empty FIFO SHALL be visible 1 cycle after the write; r_en SHALL pop the head.
REQ-023 A rejected write or read SHALL leave pointers, memory, count and data_out unchanged.

Reset
REQ-024 arst=1 SHALL immediately set wr_ptr, rd_ptr and count to 0, empty and almost_empty to 1, full and almost_full to 0, and data_out to 0.
REQ-025 Memory contents SHALL NOT be reset.
REQ-026 Assertion of reset mid-operation SHALL discard all stored words; the first write after release SHALL be accepted normally.

Configuration
REQ-027 With macro SYNC_FIFO_ERR_FLAGS_EN defined, the block SHALL add outputs overflow and underflow, 1 bit each, set sticky by a rejected w_en or r_en respectively and cleared only by arst.
REQ-028 Without SYNC_FIFO_ERR_FLAGS_EN, those ports and their logic SHALL be absent, and rejected requests SHALL be silently ignored.

Structure
REQ-029 Package sync_fifo_pkg SHALL hold the FWFT mode constants and a helper function computing PTR_LEN from SIZE.
REQ-030 Storage SHALL be a sub-module sync_fifo_ram with one synchronous write port and one read port indexed by the low PTR_LEN pointer bits; the pointer, count and flag logic SHALL reside in sync_fifo.

Verification (SIZE=8, WIDTH=8, AFULL_TH=6, AEMPTY_TH=1)
REQ-031 Fill check: write 0x01..0x08 -> almost_full=1 after the 6th write, full=1 with count=8 after the 8th; a 9th write of 0xFF SHALL be dropped, and overflow=1 when SYNC_FIFO_ERR_FLAGS_EN is defined.
REQ-032 Drain check (FWFT=0): read 8 times -> data_out=0x01..0x08, each value 1 cycle after its read; empty=1 after the last read; a 9th read SHALL leave data_out=0x08, with underflow=1 under the macro.
REQ-033 Simultaneous access: with count=4, assert w_en and r_en together for 10 cycles -> count stays 4, and data order is preserved across pointer wrap.
REQ-034 FWFT=1: write 0xA5 into an empty FIFO -> data_out=0xA5 and empty=0 one cycle later without r_en; pulsing r_en -> empty=1.
REQ-035 Reset mid-operation: with count=5, pulse arst asynchronously -> count=0, empty=1 and data_out=0 at once; a following write of 0x3C SHALL read back 0x3C.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
// Shared constants for the synchronous FIFO:
//   FWFT_OFF / FWFT_ON : read-mode selectors for the FWFT parameter
//   calc_ptr_len()     : address width needed to index SIZE words
package sync_fifo_pkg;

    localparam int FWFT_OFF = 0;  // registered read data, updated on pop
    localparam int FWFT_ON  = 1;  // head word presented without a read

    // Address width for a power-of-two depth; never narrower than 1 bit.
    function automatic int calc_ptr_len(input int size);
        return (size < 2) ? 1 : $clog2(size);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram
// Storage array for sync_fifo: one synchronous write port, one
// combinational read port. Contents are never reset.
// Ports:
//   clk     : write clock (rising edge)
//   we_i    : write enable
//   waddr_i : write address (low pointer bits)
//   wdata_i : write data
//   raddr_i : read address (low pointer bits)
//   rdata_o : word at raddr_i
module sync_fifo_ram #(
    parameter int WIDTH   = 8,
    parameter int SIZE    = 8,
    parameter int PTR_LEN = 3
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [PTR_LEN-1:0] waddr_i,
    input  logic [WIDTH-1:0]   wdata_i,
    input  logic [PTR_LEN-1:0] raddr_i,
    output logic [WIDTH-1:0]   rdata_o
);

    logic [WIDTH-1:0] mem_q [SIZE];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with registered count and status flags and a choice
// of standard or first-word-fall-through read behaviour.
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN adds sticky
// overflow/underflow outputs.
// Ports:
//   clk          : clock, rising edge
//   arst         : asynchronous active-high reset
//   w_en/data_in : write request and data
//   r_en         : read request (pop of the head word in FWFT mode)
//   data_out     : read data
//   full, empty, almost_full, almost_empty : registered status flags
//   count        : number of stored words, 0..SIZE
//   overflow/underflow (macro only) : sticky rejected-request flags
//
// Handshake: w_en and r_en are single-cycle requests. A write is accepted
// in a cycle where w_en=1 and full=0; a read is accepted where r_en=1 and
// empty=0. There is no stall: a rejected request is simply lost and leaves
// all state untouched (other than the optional sticky error flags).
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SIZE      = 8,
    parameter int PTR_LEN   = calc_ptr_len(SIZE),
    parameter int AFULL_TH  = SIZE - 2,
    parameter int AEMPTY_TH = 1,
    parameter int FWFT      = FWFT_OFF
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               w_en,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               r_en,
    output logic [WIDTH-1:0]   data_out,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    output logic               overflow,
    output logic               underflow,
`endif
    output logic [PTR_LEN:0]   count
);

    localparam logic [PTR_LEN:0] PTR_ONE  = (PTR_LEN+1)'(1);
    localparam logic [PTR_LEN:0] SIZE_C   = (PTR_LEN+1)'(SIZE);
    localparam logic [PTR_LEN:0] AFULL_C  = (PTR_LEN+1)'(AFULL_TH);
    localparam logic [PTR_LEN:0] AEMPTY_C = (PTR_LEN+1)'(AEMPTY_TH);

    // Pointers carry one extra MSB so that equal low bits with differing
    // MSBs means full rather than empty.
    logic [PTR_LEN:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_LEN:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_LEN:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;

    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] ram_rdata;

    always_comb begin
        wr_acc   = w_en & ~full_q;
        rd_acc   = r_en & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase
        // Flags are derived from the next count so they line up with it.
        full_d   = (count_d == SIZE_C);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    sync_fifo_ram #(
        .WIDTH   (WIDTH),
        .SIZE    (SIZE),
        .PTR_LEN (PTR_LEN)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[PTR_LEN-1:0]),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q[PTR_LEN-1:0]),
        .rdata_o (ram_rdata)
    );

    generate
        if (FWFT == FWFT_ON) begin : g_fwft
            // The read port always addresses the head, so the head word is
            // visible as soon as empty drops; forced to zero while empty so
            // reset and drain leave a clean output.
            assign data_out = empty_q ? '0 : ram_rdata;
        end else begin : g_std
            logic [WIDTH-1:0] dout_q, dout_d;

            always_comb begin
                dout_d = dout_q;
                if (rd_acc) begin
                    dout_d = ram_rdata;
                end
            end

            always_ff @(posedge clk or posedge arst) begin
                if (arst) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q | (w_en & full_q);
        unf_d = unf_q | (r_en & empty_q);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif

    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo
// Drives a standard-read and an FWFT instance of sync_fifo with identical
// stimulus and compares both against a queue model of the FIFO contents.
module tb_sync_fifo;

    localparam int W     = 8;
    localparam int DEPTH = 8;
    localparam int AF_TH = 6;
    localparam int AE_TH = 1;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic arst = 1'b1;

    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic         w_en    = 1'b0;
    logic         r_en    = 1'b0;
    logic [W-1:0] data_in = '0;

    logic [W-1:0] dout_s, dout_f;
    logic         full_s, empty_s, af_s, ae_s;
    logic         full_f, empty_f, af_f, ae_f;
    logic [3:0]   cnt_s, cnt_f;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic         ovf_s, unf_s, ovf_f, unf_f;
`endif

    sync_fifo #(
        .WIDTH(W), .SIZE(DEPTH), .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH), .FWFT(0)
    ) u_std (
        .clk          (clk),
        .arst         (arst),
        .w_en         (w_en),
        .data_in      (data_in),
        .r_en         (r_en),
        .data_out     (dout_s),
        .full         (full_s),
        .empty        (empty_s),
        .almost_full  (af_s),
        .almost_empty (ae_s),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .overflow     (ovf_s),
        .underflow    (unf_s),
`endif
        .count        (cnt_s)
    );

    sync_fifo #(
        .WIDTH(W), .SIZE(DEPTH), .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH), .FWFT(1)
    ) u_fwft (
        .clk          (clk),
        .arst         (arst),
        .w_en         (w_en),
        .data_in      (data_in),
        .r_en         (r_en),
        .data_out     (dout_f),
        .full         (full_f),
        .empty        (empty_f),
        .almost_full  (af_f),
        .almost_empty (ae_f),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .overflow     (ovf_f),
        .underflow    (unf_f),
`endif
        .count        (cnt_f)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] mdl_q[$];   // words the FIFO should be holding
    logic [W-1:0] exp_q[$];   // read results awaiting the DUT output
    logic [W-1:0] exp_hold;   // expected standard-mode data_out
    logic         ovf_m;
    logic         unf_m;
    int           n_checks;
    int           n_fail;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int c;
        c = mdl_q.size();
        check_eq("count_std",  32'(cnt_s),   32'(c));
        check_eq("count_fwft", 32'(cnt_f),   32'(c));
        check_eq("full",       32'(full_s),  32'(c == DEPTH));
        check_eq("empty",      32'(empty_s), 32'(c == 0));
        check_eq("empty_fwft", 32'(empty_f), 32'(c == 0));
        check_eq("afull",      32'(af_s),    32'(c >= AF_TH));
        check_eq("aempty",     32'(ae_s),    32'(c <= AE_TH));
        check_eq("dout_std",   32'(dout_s),  32'(exp_hold));
        if (c > 0) begin
            check_eq("dout_fwft_head", 32'(dout_f), 32'(mdl_q[0]));
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check_eq("overflow",  32'(ovf_s), 32'(ovf_m));
        check_eq("underflow", 32'(unf_s), 32'(unf_m));
        check_eq("overflow_fwft",  32'(ovf_f), 32'(ovf_m));
        check_eq("underflow_fwft", 32'(unf_f), 32'(unf_m));
`endif
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after a rising edge and are sampled at the
    // next one; outputs are checked 1 time unit after that edge.
    task automatic do_op(input logic w, input logic [W-1:0] d, input logic r);
        logic w_acc, r_acc;
        w_acc = w && (mdl_q.size() < DEPTH);
        r_acc = r && (mdl_q.size() > 0);
        if (r_acc) exp_q.push_back(mdl_q.pop_front());
        if (w_acc) mdl_q.push_back(d);
        if (w && !w_acc) ovf_m = 1'b1;
        if (r && !r_acc) unf_m = 1'b1;
        w_en    = w;
        data_in = d;
        r_en    = r;
        @(posedge clk);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
        if (r_acc) exp_hold = exp_q.pop_front();
        check_state();
    endtask

    task automatic clear_model();
        mdl_q.delete();
        exp_q.delete();
        exp_hold = '0;
        ovf_m    = 1'b0;
        unf_m    = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_model();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_dout_fwft", 32'(dout_f), 32'h0);
        check_state();
        arst = 1'b0;
        @(posedge clk);
        #1;

        // Fill 0x01..0x08, then a dropped 9th write
        for (int i = 1; i <= DEPTH; i++) begin
            do_op(1'b1, W'(i), 1'b0);
            if (i == AF_TH) check_eq("afull_at_6", 32'(af_s), 32'h1);
        end
        check_eq("full_at_8", 32'(full_s), 32'h1);
        do_op(1'b1, 8'hFF, 1'b0);
        check_eq("count_after_drop", 32'(cnt_s), 32'h8);

        // Drain, then a rejected 9th read
        for (int i = 1; i <= DEPTH; i++) begin
            do_op(1'b0, '0, 1'b1);
            check_eq("drain_data", 32'(dout_s), 32'(i));
        end
        do_op(1'b0, '0, 1'b1);
        check_eq("dout_hold_after_underrun", 32'(dout_s), 32'h08);

        // FWFT: word falls through without r_en, then pop empties
        do_op(1'b1, 8'hA5, 1'b0);
        check_eq("fwft_a5", 32'(dout_f), 32'hA5);
        check_eq("fwft_not_empty", 32'(empty_f), 32'h0);
        do_op(1'b0, '0, 1'b1);
        check_eq("fwft_empty_after_pop", 32'(empty_f), 32'h1);

        // Simultaneous access at count=4, across pointer wrap
        for (int i = 0; i < 4; i++) do_op(1'b1, W'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 10; i++) begin
            do_op(1'b1, W'($urandom_range(0, 255)), 1'b1);
            check_eq("simul_count", 32'(cnt_s), 32'h4);
        end
        for (int i = 0; i < 4; i++) do_op(1'b0, '0, 1'b1);

        // Asynchronous reset mid-operation at count=5
        for (int i = 0; i < 5; i++) do_op(1'b1, W'(8'h50 + i), 1'b0);
        #3;
        arst = 1'b1;
        #1;
        clear_model();
        check_eq("arst_count",     32'(cnt_s),   32'h0);
        check_eq("arst_empty",     32'(empty_s), 32'h1);
        check_eq("arst_dout",      32'(dout_s),  32'h0);
        check_eq("arst_dout_fwft", 32'(dout_f),  32'h0);
        check_state();
        @(posedge clk);
        #1;
        arst = 1'b0;
        do_op(1'b1, 8'h3C, 1'b0);
        check_eq("post_rst_fwft", 32'(dout_f), 32'h3C);
        do_op(1'b0, '0, 1'b1);
        check_eq("post_rst_read", 32'(dout_s), 32'h3C);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            do_op(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
        end

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
